uart_cmd_parser: RTL and testbench

- Sits between the UART receiver and the serial-output engine.
- Consumes received bytes (`rx_data` / `rx_done_tick`) and frames them into host commands: DATA, CTRL, FREQ, PERIOD, REPEAT, GLOBAL.
- Emits one decoded, fully assembled write transaction per valid frame.
- Rejects malformed frames with an error pulse, and recovers from truncated frames with an inter-byte timeout.

---
 rtl/uart_cmd_parser_pkg.sv | 48 ++++
 rtl/frame_timeout_counter.sv | 33 +++
 rtl/uart_cmd_parser.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART host-command parser.
//   CMD_*      : command bytes recognised at the start of a frame
//   WR_TYPE_*  : transaction type encodings presented on wr_type_o
//   ERR_*      : error codes presented on err_code_o
//   decode_cmd : maps a leading byte to {known, wr_type}
package uart_cmd_parser_pkg;

    localparam logic [7:0] CMD_DATA   = 8'hA0;
    localparam logic [7:0] CMD_CTRL   = 8'hA1;
    localparam logic [7:0] CMD_FREQ   = 8'hA2;
    localparam logic [7:0] CMD_PERIOD = 8'hA3;
    localparam logic [7:0] CMD_REPEAT = 8'hA4;
    localparam logic [7:0] CMD_GLOBAL = 8'hA5;

    localparam logic [2:0] WR_TYPE_DATA   = 3'd0;
    localparam logic [2:0] WR_TYPE_CTRL   = 3'd1;
    localparam logic [2:0] WR_TYPE_FREQ   = 3'd2;
    localparam logic [2:0] WR_TYPE_PERIOD = 3'd3;
    localparam logic [2:0] WR_TYPE_REPEAT = 3'd4;
    localparam logic [2:0] WR_TYPE_GLOBAL = 3'd5;

    localparam logic [1:0] ERR_UNKNOWN_CMD = 2'd0;
    localparam logic [1:0] ERR_BAD_CH      = 2'd1;
    localparam logic [1:0] ERR_BAD_AMT     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

    typedef struct packed {
        logic       known;
        logic [2:0] wr_type;
    } cmd_dec_t;

    function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
        cmd_dec_t d;
        d.known   = 1'b1;
        d.wr_type = WR_TYPE_DATA;
        case (b)
            CMD_DATA:   d.wr_type = WR_TYPE_DATA;
            CMD_CTRL:   d.wr_type = WR_TYPE_CTRL;
            CMD_FREQ:   d.wr_type = WR_TYPE_FREQ;
            CMD_PERIOD: d.wr_type = WR_TYPE_PERIOD;
            CMD_REPEAT: d.wr_type = WR_TYPE_REPEAT;
            CMD_GLOBAL: d.wr_type = WR_TYPE_GLOBAL;
            default:    d.known   = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte idle counter for frame recovery.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : restart counting from zero (wins over enable)
//   enable_i     : count one idle cycle
//   expire_o     : single-cycle pulse on the cycle the count reaches TIMEOUT_CYCLES
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Limit   = CntW'(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LimitM1 = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != Limit)) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Fires on the increment that lands on Limit; saturation keeps it one-shot.
    assign expire_o = enable_i && !clear_i && (cnt_q == LimitM1);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames received UART bytes into host write transactions.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   data_i           : received byte, qualified by rx_done_tick_i
//   rx_done_tick_i   : byte-valid strobe
//   wr_valid_o       : one-cycle pulse, wr_* fields valid (held until next transaction)
//   wr_type_o        : command type
//   wr_channel_o     : target channel (DATA/CTRL/REPEAT, else 0)
//   wr_amount_o      : amount byte (DATA/FREQ, else 0)
//   wr_data_o        : assembled payload, LSB byte first
//   err_o/err_code_o : one-cycle error pulse and its code
//   busy_o           : frame in progress
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned DATA_BIT       = 32,
    parameter int unsigned OUTPUT_NUM     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    data_i,
    input  logic                          rx_done_tick_i,
    output logic                          wr_valid_o,
    output logic [2:0]                    wr_type_o,
    output logic [$clog2(OUTPUT_NUM)-1:0] wr_channel_o,
    output logic [7:0]                    wr_amount_o,
    output logic [DATA_BIT-1:0]           wr_data_o,
    output logic                          err_o,
    output logic [1:0]                    err_code_o,
    output logic                          busy_o
);

    localparam int unsigned MaxBytes = DATA_BIT / 8;
    localparam int unsigned IdxW     = $clog2(MaxBytes);
    localparam int unsigned ChW      = $clog2(OUTPUT_NUM);

    typedef enum logic [2:0] {
        StIdle, StGetCh, StGetAmt, StGetPayload, StGetArg0, StGetArg1, StDrain
    } state_e;

    state_e              state_q;
    logic [2:0]          type_q;
    logic [ChW-1:0]      ch_q;
    logic [7:0]          amt_q;
    logic [DATA_BIT-1:0] pay_q;
    logic [IdxW-1:0]     idx_q;
    logic                bad_ch_q;

    logic                wr_valid_q, err_q;
    logic [2:0]          wr_type_q;
    logic [ChW-1:0]      wr_channel_q;
    logic [7:0]          wr_amount_q;
    logic [DATA_BIT-1:0] wr_data_q;
    logic [1:0]          err_code_q;

    cmd_dec_t            cmd_dec;
    logic [IdxW-1:0]     byte_pos;
    logic [DATA_BIT-1:0] pay_merged;
    logic                frame_done;
    logic                expire;

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (rx_done_tick_i || (state_q == StIdle)),
        .enable_i (state_q != StIdle),
        .expire_o (expire)
    );

    // Payload including the byte arriving this cycle, so completion can publish it directly.
    always_comb begin
        cmd_dec  = decode_cmd(data_i);
        byte_pos = idx_q;
        if (state_q == StGetArg0) begin
            byte_pos = '0;
        end else if (state_q == StGetArg1) begin
            byte_pos = IdxW'(1);
        end
        pay_merged = pay_q;
        pay_merged[{byte_pos, 3'b000} +: 8] = data_i;
        frame_done = rx_done_tick_i &&
                     (((state_q == StGetPayload) && (8'(idx_q) == amt_q)) ||
                      ((state_q == StGetArg0) && (type_q != WR_TYPE_PERIOD)) ||
                      (state_q == StGetArg1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            type_q       <= '0;
            ch_q         <= '0;
            amt_q        <= '0;
            pay_q        <= '0;
            idx_q        <= '0;
            bad_ch_q     <= 1'b0;
            wr_valid_q   <= 1'b0;
            err_q        <= 1'b0;
            wr_type_q    <= '0;
            wr_channel_q <= '0;
            wr_amount_q  <= '0;
            wr_data_q    <= '0;
            err_code_q   <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (rx_done_tick_i) begin
                unique case (state_q)
                    StIdle: begin
                        ch_q     <= '0;
                        amt_q    <= '0;
                        pay_q    <= '0;
                        idx_q    <= '0;
                        bad_ch_q <= 1'b0;
                        type_q   <= cmd_dec.wr_type;
                        if (!cmd_dec.known) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_UNKNOWN_CMD;
                        end else if (cmd_dec.wr_type == WR_TYPE_FREQ) begin
                            state_q <= StGetAmt;
                        end else if ((cmd_dec.wr_type == WR_TYPE_PERIOD) ||
                                     (cmd_dec.wr_type == WR_TYPE_GLOBAL)) begin
                            state_q <= StGetArg0;
                        end else begin
                            state_q <= StGetCh;
                        end
                    end
                    StGetCh: begin
                        ch_q <= ChW'(data_i);
                        // Bad channel is reported only at frame end to keep byte framing intact.
                        if (32'(data_i) >= OUTPUT_NUM) begin
                            bad_ch_q <= 1'b1;
                        end
                        state_q <= (type_q == WR_TYPE_DATA) ? StGetAmt : StGetArg0;
                    end
                    StGetAmt: begin
                        amt_q <= data_i;
                        if (32'(data_i) >= MaxBytes) begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_BAD_AMT;
                            state_q    <= StDrain;
                        end else begin
                            pay_q   <= '0;
                            idx_q   <= '0;
                            state_q <= StGetPayload;
                        end
                    end
                    StGetPayload: begin
                        pay_q <= pay_merged;
                        idx_q <= idx_q + IdxW'(1);
                    end
                    StGetArg0: begin
                        pay_q   <= pay_merged;
                        state_q <= StGetArg1;
                    end
                    StGetArg1: begin
                        pay_q <= pay_merged;
                    end
                    StDrain: begin
                        state_q <= StDrain;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase

                if (frame_done) begin
                    state_q <= StIdle;
                    if (bad_ch_q) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_BAD_CH;
                    end else begin
                        wr_valid_q   <= 1'b1;
                        wr_type_q    <= type_q;
                        wr_channel_q <= ch_q;
                        wr_amount_q  <= amt_q;
                        wr_data_q    <= pay_merged;
                    end
                end
            end else if (expire) begin
                // Drain already reported its error; leave quietly.
                if (state_q != StDrain) begin
                    err_q      <= 1'b1;
                    err_code_q <= ERR_TIMEOUT;
                end
                state_q <= StIdle;
            end
        end
    end

    assign wr_valid_o   = wr_valid_q;
    assign wr_type_o    = wr_type_q;
    assign wr_channel_o = wr_channel_q;
    assign wr_amount_o  = wr_amount_q;
    assign wr_data_o    = wr_data_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser.
module tb_uart_cmd_parser;
    import uart_cmd_parser_pkg::*;

    localparam int unsigned T = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        tick;
    logic        wr_valid;
    logic [2:0]  wr_type;
    logic [3:0]  wr_channel;
    logic [7:0]  wr_amount;
    logic [31:0] wr_data;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int nerr   = 0;
    bit both_seen = 1'b0;

    uart_cmd_parser #(
        .DATA_BIT       (32),
        .OUTPUT_NUM     (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (data),
        .rx_done_tick_i (tick),
        .wr_valid_o     (wr_valid),
        .wr_type_o      (wr_type),
        .wr_channel_o   (wr_channel),
        .wr_amount_o    (wr_amount),
        .wr_data_o      (wr_data),
        .err_o          (err),
        .err_code_o     (err_code),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) nvalid++;
        if (err) nerr++;
        if (wr_valid && err) both_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; tick sampled at the next edge, returns at that edge+1.
    task automatic send(input logic [7:0] b);
        data = b;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", wr_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", wr_data); end
        checks++; if ({wr_type, wr_channel, wr_amount, err_code} !== 17'h0) begin
            errors++; $display("FAIL reset_fields got %0h exp 0", {wr_type, wr_channel, wr_amount, err_code});
        end
    endtask

    task automatic test_data_frame;
        int v0 = nvalid;
        send(CMD_DATA); send(8'h01); send(8'h02); send(8'h55); send(8'h66);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL data_busy got %0h exp 1", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL data_early got %0h exp 0", wr_valid); end
        send(8'h77);
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL data_valid got %0h exp 1", wr_valid); end
        checks++; if (wr_type !== WR_TYPE_DATA) begin errors++; $display("FAIL data_type got %0h exp 0", wr_type); end
        checks++; if (wr_channel !== 4'd1) begin errors++; $display("FAIL data_ch got %0h exp 1", wr_channel); end
        checks++; if (wr_amount !== 8'd2) begin errors++; $display("FAIL data_amt got %0h exp 2", wr_amount); end
        checks++; if (wr_data !== 32'h0077_6655) begin errors++; $display("FAIL data_payload got %0h exp 776655", wr_data); end
        idle(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL data_busy_after got %0h exp 0", busy); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL data_pulse_width got %0h exp 0", wr_valid); end
        checks++; if (wr_data !== 32'h0077_6655) begin errors++; $display("FAIL data_hold got %0h exp 776655", wr_data); end
        checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL data_count got %0d exp 1", nvalid - v0); end
    endtask

    task automatic test_back_to_back;
        int e0 = nerr;
        send(CMD_PERIOD); send(8'h14); send(8'h05);
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL period_valid got %0h exp 1", wr_valid); end
        checks++; if (wr_type !== WR_TYPE_PERIOD) begin errors++; $display("FAIL period_type got %0h exp 3", wr_type); end
        checks++; if (wr_data !== 32'h0000_0514) begin errors++; $display("FAIL period_data got %0h exp 514", wr_data); end
        checks++; if ({wr_channel, wr_amount} !== 12'h0) begin
            errors++; $display("FAIL period_ch_amt got %0h exp 0", {wr_channel, wr_amount});
        end
        send(CMD_GLOBAL);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL global_busy got %0h exp 1", busy); end
        send(8'h01);
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL global_valid got %0h exp 1", wr_valid); end
        checks++; if (wr_type !== WR_TYPE_GLOBAL) begin errors++; $display("FAIL global_type got %0h exp 5", wr_type); end
        checks++; if (wr_data !== 32'h1) begin errors++; $display("FAIL global_data got %0h exp 1", wr_data); end
        idle(1);
        checks++; if (nerr - e0 !== 0) begin errors++; $display("FAIL b2b_errors got %0d exp 0", nerr - e0); end
    endtask

    task automatic test_bad_channel;
        int v0 = nvalid;
        send(CMD_CTRL); send(8'h10);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL badch_early_err got %0h exp 0", err); end
        send(8'h03);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badch_err got %0h exp 1", err); end
        checks++; if (err_code !== ERR_BAD_CH) begin errors++; $display("FAIL badch_code got %0h exp 1", err_code); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL badch_valid got %0h exp 0", wr_valid); end
        idle(1);
        send(CMD_CTRL); send(8'h00); send(8'h03);
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL ctrl_valid got %0h exp 1", wr_valid); end
        checks++; if ({wr_type, wr_channel} !== {WR_TYPE_CTRL, 4'd0}) begin
            errors++; $display("FAIL ctrl_type_ch got %0h exp 10", {wr_type, wr_channel});
        end
        checks++; if (wr_data !== 32'h3) begin errors++; $display("FAIL ctrl_data got %0h exp 3", wr_data); end
        idle(1);
        checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL badch_count got %0d exp 1", nvalid - v0); end
    endtask

    task automatic test_bad_amount;
        int e0 = nerr;
        send(CMD_FREQ); send(8'h04);
        checks++; if ({err, err_code} !== {1'b1, ERR_BAD_AMT}) begin
            errors++; $display("FAIL badamt_err got %0h exp 6", {err, err_code});
        end
        send(CMD_DATA); send(8'hFF); send(8'h11); send(CMD_GLOBAL); send(8'h22);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %0h exp 1", busy); end
        idle(T - 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_early_idle got %0h exp 1", busy); end
        idle(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_timeout got %0h exp 0", busy); end
        checks++; if (nerr - e0 !== 1) begin errors++; $display("FAIL badamt_count got %0d exp 1", nerr - e0); end
        send(CMD_FREQ); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL freq_valid got %0h exp 1", wr_valid); end
        checks++; if ({wr_type, wr_channel, wr_amount} !== {WR_TYPE_FREQ, 4'd0, 8'd3}) begin
            errors++; $display("FAIL freq_fields got %0h exp 2003", {wr_type, wr_channel, wr_amount});
        end
        checks++; if (wr_data !== 32'hD4C3_B2A1) begin errors++; $display("FAIL freq_data got %0h exp d4c3b2a1", wr_data); end
        idle(1);
    endtask

    task automatic test_timeout;
        send(CMD_REPEAT); send(8'h0F);
        idle(T - 1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_early got %0h exp 0", err); end
        idle(1);
        checks++; if ({err, err_code} !== {1'b1, ERR_TIMEOUT}) begin
            errors++; $display("FAIL tmo_err got %0h exp 7", {err, err_code});
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %0h exp 0", busy); end
        idle(1);
        // Byte arriving on the expiry cycle completes the frame instead.
        send(CMD_REPEAT); send(8'h0F);
        idle(T - 1);
        send(8'h5A);
        checks++; if ({wr_valid, err} !== 2'b10) begin errors++; $display("FAIL tmo_race got %0h exp 2", {wr_valid, err}); end
        checks++; if ({wr_type, wr_channel} !== {WR_TYPE_REPEAT, 4'hF}) begin
            errors++; $display("FAIL repeat_fields got %0h exp 4f", {wr_type, wr_channel});
        end
        checks++; if (wr_data !== 32'h5A) begin errors++; $display("FAIL repeat_data got %0h exp 5a", wr_data); end
        idle(1);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_race_late got %0h exp 0", err); end
    endtask

    task automatic test_unknown;
        send(8'hFF);
        checks++; if ({err, err_code} !== {1'b1, ERR_UNKNOWN_CMD}) begin
            errors++; $display("FAIL unk_err got %0h exp 4", {err, err_code});
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unk_busy got %0h exp 0", busy); end
        idle(1);
        checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL unk_after got %0h exp 0", {err, busy}); end
    endtask

    task automatic test_reset_mid_frame;
        int v0 = nvalid;
        int e0 = nerr;
        send(CMD_DATA); send(8'h01); send(8'h02); send(8'h55);
        rst = 1'b1;
        idle(1);
        test_reset();
        rst = 1'b0;
        idle(T + 5);
        checks++; if ((nvalid - v0) + (nerr - e0) !== 0) begin
            errors++; $display("FAIL rst_pulses got %0d exp 0", (nvalid - v0) + (nerr - e0));
        end
        send(CMD_GLOBAL); send(8'h00);
        checks++; if ({wr_valid, wr_type} !== {1'b1, WR_TYPE_GLOBAL}) begin
            errors++; $display("FAIL rst_recover got %0h exp d", {wr_valid, wr_type});
        end
        idle(1);
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        data = 8'h00;
        idle(3);
        test_reset();
        rst = 1'b0;
        idle(1);
        test_data_frame();
        test_back_to_back();
        test_bad_channel();
        test_bad_amount();
        test_timeout();
        test_unknown();
        test_reset_mid_frame();
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL valid_err_overlap got 1 exp 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
